// File: rtl/shaper_filter_2018.sv
// Runtime-configurable pulse shaper (bypass / boxcar / trapezoid with pole-zero term)
// with a threshold peak detector and a flush/settle sequence after each accepted config.
module shaper_filter_2018 #(
    parameter int unsigned ADC_W      = 12,
    parameter int unsigned OUT_W      = 24,
    parameter int unsigned DEPTH_LOG2 = 5,
    parameter int unsigned M_W        = 10,
    parameter int unsigned SHIFT      = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADC_W-1:0]      input_data,
    input  logic                  cfg_load,
    input  logic [1:0]            cfg_mode,
    input  logic [DEPTH_LOG2-1:0] cfg_k,
    input  logic [DEPTH_LOG2-1:0] cfg_l,
    input  logic [M_W-1:0]        cfg_m,
    input  logic [OUT_W-1:0]      threshold,
    output logic [OUT_W-1:0]      output_data,
    output logic                  busy,
    output logic                  cfg_err,
    output logic                  peak_valid,
    output logic [OUT_W-1:0]      peak_value
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned ACC_W = ADC_W + 2 * DEPTH_LOG2 + M_W + 2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 2;
    localparam logic [DEPTH_LOG2:0] KL_MAX = (DEPTH_LOG2 + 1)'(DEPTH - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI =
        signed'({{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_LO =
        signed'({{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}});

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_BOXCAR = 2'd1,
        MODE_TRAP   = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        PK_IDLE,
        PK_ARMED,
        PK_EMIT
    } pk_state_t;

    mode_t                  mode_q;
    logic [DEPTH_LOG2-1:0]  k_q, l_q, kl_idx;
    logic [M_W-1:0]         m_q;
    logic [DEPTH_LOG2:0]    cfg_kl_sum;
    logic                   cfg_ok, accept;
    logic [CNT_W-1:0]       settle_cnt;

    logic [ADC_W-1:0]        hist [DEPTH];
    logic signed [ACC_W-1:0] x0_s, xk_s, xl_s, xkl_s, m_ext, y_sh;
    logic signed [ACC_W-1:0] d_q, p_q, d2_q, r_q, y4_q;
    logic [OUT_W-1:0]        out_q;

    pk_state_t               pk_state, pk_next;
    logic signed [OUT_W-1:0] y_s, thr_s, max_q;

    always_comb begin
        cfg_kl_sum = {1'b0, cfg_k} + {1'b0, cfg_l};
        cfg_ok     = (mode_t'(cfg_mode) != MODE_RSVD) && (cfg_k != '0) &&
                     (cfg_l >= cfg_k) && (cfg_kl_sum <= KL_MAX);
        accept     = cfg_load && cfg_ok;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q     <= MODE_BYPASS;
            k_q        <= DEPTH_LOG2'(1);
            l_q        <= DEPTH_LOG2'(2);
            m_q        <= '0;
            cfg_err    <= 1'b0;
            busy       <= 1'b0;
            settle_cnt <= '0;
        end else begin
            if (cfg_load) begin
                if (cfg_ok) begin
                    mode_q  <= mode_t'(cfg_mode);
                    k_q     <= cfg_k;
                    l_q     <= cfg_l;
                    m_q     <= cfg_m;
                    cfg_err <= 1'b0;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
            // Count holds the remaining busy cycles after the current one.
            if (accept) begin
                busy       <= 1'b1;
                settle_cnt <= CNT_W'(cfg_k) + CNT_W'(cfg_l) + CNT_W'(4);
            end else if (busy) begin
                if (settle_cnt == '0) busy <= 1'b0;
                else                  settle_cnt <= settle_cnt - CNT_W'(1);
            end
        end
    end

    always_comb begin
        kl_idx = k_q + l_q;
        x0_s   = signed'(ACC_W'(hist[0]));
        xk_s   = signed'(ACC_W'(hist[k_q]));
        xl_s   = signed'(ACC_W'(hist[l_q]));
        xkl_s  = signed'(ACC_W'(hist[kl_idx]));
        m_ext  = signed'(ACC_W'(m_q));
        y_sh   = y4_q >>> SHIFT;
    end

    always_ff @(posedge clk) begin
        if (!reset || accept) begin
            for (int unsigned i = 0; i < DEPTH; i++) hist[i] <= '0;
            d_q   <= '0;
            p_q   <= '0;
            d2_q  <= '0;
            r_q   <= '0;
            y4_q  <= '0;
            out_q <= '0;
        end else begin
            hist[0] <= input_data;
            for (int unsigned i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
            d_q  <= (mode_q == MODE_TRAP) ? (x0_s - xk_s - xl_s + xkl_s) : (x0_s - xk_s);
            p_q  <= p_q + d_q;
            d2_q <= d_q;
            r_q  <= (mode_q == MODE_TRAP) ? (p_q + m_ext * d2_q) : p_q;
            // Shaped modes take the corrected sum r, so m=0 yields the plain trapezoid.
            y4_q <= (mode_q == MODE_BYPASS) ? signed'(ACC_W'(hist[3])) : r_q;
            if (y_sh > SAT_HI)      out_q <= SAT_HI[OUT_W-1:0];
            else if (y_sh < SAT_LO) out_q <= SAT_LO[OUT_W-1:0];
            else                    out_q <= y_sh[OUT_W-1:0];
        end
    end

    always_comb begin
        output_data = busy ? '0 : out_q;
    end

    always_comb begin
        y_s     = signed'(output_data);
        thr_s   = signed'(threshold);
        pk_next = pk_state;
        case (pk_state)
            PK_IDLE:  if (y_s > thr_s)  pk_next = PK_ARMED;
            PK_ARMED: if (y_s <= thr_s) pk_next = PK_EMIT;
            default:  pk_next = PK_IDLE;
        endcase
        if (busy || accept) pk_next = PK_IDLE;
        peak_valid = (pk_state == PK_EMIT);
    end

    always_ff @(posedge clk) begin
        if (!reset) pk_state <= PK_IDLE;
        else        pk_state <= pk_next;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            max_q      <= '0;
            peak_value <= '0;
        end else begin
            if (pk_state == PK_IDLE && pk_next == PK_ARMED)
                max_q <= y_s;
            else if (pk_state == PK_ARMED && pk_next == PK_ARMED && y_s > max_q)
                max_q <= y_s;
            if (pk_state == PK_ARMED && pk_next == PK_EMIT)
                peak_value <= max_q;
        end
    end

endmodule

// File: tb/tb_shaper_filter_2018.sv
// Self-checking bench for shaper_filter_2018: window-sum reference model feeding a
// latency-5 scoreboard, a config-check vector table, and peak-detector sequences.
module tb_shaper_filter_2018;

    localparam int ADC_W      = 12;
    localparam int OUT_W      = 24;
    localparam int DEPTH_LOG2 = 5;
    localparam int M_W        = 10;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [ADC_W-1:0]      input_data = '0;
    logic                  cfg_load = 1'b0;
    logic [1:0]            cfg_mode = '0;
    logic [DEPTH_LOG2-1:0] cfg_k = '0;
    logic [DEPTH_LOG2-1:0] cfg_l = '0;
    logic [M_W-1:0]        cfg_m = '0;
    logic [OUT_W-1:0]      threshold = '0;
    logic [OUT_W-1:0]      output_data;
    logic                  busy;
    logic                  cfg_err;
    logic                  peak_valid;
    logic [OUT_W-1:0]      peak_value;

    shaper_filter_2018 #(
        .ADC_W(ADC_W),
        .OUT_W(OUT_W),
        .DEPTH_LOG2(DEPTH_LOG2),
        .M_W(M_W),
        .SHIFT(0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .input_data(input_data),
        .cfg_load(cfg_load),
        .cfg_mode(cfg_mode),
        .cfg_k(cfg_k),
        .cfg_l(cfg_l),
        .cfg_m(cfg_m),
        .threshold(threshold),
        .output_data(output_data),
        .busy(busy),
        .cfg_err(cfg_err),
        .peak_valid(peak_valid),
        .peak_value(peak_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mode;
        int k;
        int l;
        int m;
        int err;
        int busy_len;
    } cfg_vec_t;

    int       checks = 0;
    int       errors = 0;

    int       mode_m = 0, k_m = 1, l_m = 2, m_m = 0;
    int       err_m = 0;
    int       bcnt = 0;
    int       xs[$];
    longint   exp_q[$];
    longint   out_log[$];
    bit       pv_log[$];
    longint   pval_log[$];
    int       pv_count = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int tap(input int j);
        if (j >= xs.size()) return 0;
        return xs[xs.size() - 1 - j];
    endfunction

    // Reference: trapezoid as difference of two k-wide window sums plus M times the
    // second difference; boxcar as a plain k-wide window sum.
    function automatic longint model_y();
        longint v, w0, w1;
        if (mode_m == 0) begin
            v = tap(0);
        end else begin
            w0 = 0;
            for (int i = 0; i < k_m; i++) w0 += tap(i);
            if (mode_m == 1) begin
                v = w0;
            end else begin
                w1 = 0;
                for (int i = 0; i < k_m; i++) w1 += tap(l_m + i);
                v = w0 - w1 + longint'(m_m) * (tap(0) - tap(k_m) - tap(l_m) + tap(k_m + l_m));
            end
        end
        if (v > 64'sd8388607)  v = 64'sd8388607;
        if (v < -64'sd8388608) v = -64'sd8388608;
        return v;
    endfunction

    task automatic step();
        bit     acc;
        int     newb;
        longint exp_out;
        acc  = 1'b0;
        newb = 0;
        if (!reset) begin
            mode_m = 0; k_m = 1; l_m = 2; m_m = 0; err_m = 0;
            xs.delete();
            exp_q.delete();
            repeat (6) exp_q.push_back(0);
        end else if (cfg_load && cfg_mode != 2'd3 && cfg_k >= 1 && cfg_l >= cfg_k &&
                     int'(cfg_k) + int'(cfg_l) <= 31) begin
            acc    = 1'b1;
            mode_m = int'(cfg_mode); k_m = int'(cfg_k); l_m = int'(cfg_l); m_m = int'(cfg_m);
            err_m  = 0;
            newb   = k_m + l_m + 5;
            xs.delete();
            exp_q.delete();
            repeat (6) exp_q.push_back(0);
        end else begin
            if (cfg_load) err_m = 1;
            xs.push_back(int'(input_data));
            if (xs.size() > 64) void'(xs.pop_front());
            exp_q.push_back(model_y());
        end
        @(posedge clk);
        #1;
        if (!reset)      bcnt = 0;
        else if (acc)    bcnt = newb;
        else if (bcnt > 0) bcnt--;
        exp_out = exp_q.pop_front();
        if (bcnt > 0) exp_out = 0;
        check("output_data", longint'($signed(output_data)), exp_out);
        check("busy", longint'(busy), longint'(bcnt > 0));
        check("cfg_err", longint'(cfg_err), longint'(err_m));
        out_log.push_back(longint'($signed(output_data)));
        pv_log.push_back(peak_valid);
        pval_log.push_back(longint'(peak_value));
        if (peak_valid) pv_count++;
        cfg_load = 1'b0;
    endtask

    task automatic configure(input int mode, input int k, input int l, input int m);
        cfg_mode   = 2'(mode);
        cfg_k      = 5'(k);
        cfg_l      = 5'(l);
        cfg_m      = 10'(m);
        cfg_load   = 1'b1;
        input_data = '0;
        step();
        for (int i = 0; i < 64 && busy; i++) step();
        check("settle_done", longint'(busy), 0);
        repeat (2) step();
    endtask

    task automatic clear_logs();
        out_log.delete();
        pv_log.delete();
        pval_log.delete();
        pv_count = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1);
    end

    initial begin
        cfg_vec_t tbl[8];
        longint   trap_exp[14];
        longint   box_exp[14];
        int       pidx;
        int       bl;

        tbl[0] = '{3, 4, 8, 0, 1, 0};
        tbl[1] = '{1, 0, 4, 0, 1, 0};
        tbl[2] = '{2, 8, 4, 0, 1, 0};
        tbl[3] = '{2, 20, 20, 0, 1, 0};
        tbl[4] = '{2, 16, 16, 0, 1, 0};
        tbl[5] = '{2, 15, 16, 0, 0, 36};
        tbl[6] = '{1, 1, 1, 0, 0, 7};
        tbl[7] = '{0, 10, 20, 0, 0, 35};
        trap_exp = '{100, 200, 300, 400, 400, 400, 400, 400, 300, 200, 100, 0, 0, 0};
        box_exp  = '{100, 200, 300, 400, 400, 400, 400, 400, 400, 400, 300, 200, 100, 0};

        threshold = 24'h7FFFFF;

        // Reset held low with full-scale input, then bypass delay of five samples.
        reset      = 1'b0;
        input_data = 12'd4095;
        repeat (3) begin
            step();
            check("rst_peak_valid", longint'(peak_valid), 0);
            check("rst_peak_value", longint'(peak_value), 0);
        end
        reset = 1'b1;
        repeat (20) begin
            input_data = 12'($urandom_range(0, 4095));
            step();
        end

        // Boxcar k=4: step up then back down.
        configure(1, 4, 4, 0);
        clear_logs();
        for (int i = 0; i < 20; i++) begin
            input_data = (i < 10) ? 12'd100 : 12'd0;
            step();
        end
        for (int n = 0; n < 14; n++) check("boxcar_step", out_log[5 + n], box_exp[n]);

        // Trapezoid k=4 l=8 m=0 step response with the peak detector armed at 250.
        threshold = 24'd250;
        configure(2, 4, 8, 0);
        clear_logs();
        for (int i = 0; i < 24; i++) begin
            input_data = 12'd100;
            step();
        end
        for (int n = 0; n < 14; n++) check("trap_step", out_log[5 + n], trap_exp[n]);
        pidx = -1;
        for (int i = 0; i < pv_log.size(); i++) if (pv_log[i] && pidx < 0) pidx = i;
        check("peak_count", pv_count, 1);
        check("peak_cycle", pidx, 15);
        check("peak_value", pval_log[15], 400);
        check("peak_hold", pval_log[23], 400);

        // Accepted reload while the detector is armed: pulse aborted, output flushed.
        input_data = '0;
        configure(2, 4, 8, 0);
        clear_logs();
        for (int i = 0; i < 10; i++) begin
            input_data = 12'd100;
            step();
        end
        cfg_mode = 2'd2; cfg_k = 5'd4; cfg_l = 5'd8; cfg_m = '0;
        cfg_load = 1'b1;
        input_data = '0;
        step();
        repeat (45) step();
        check("abort_no_peak", pv_count, 0);

        // Pole-zero term with random data, then full-scale square wave into saturation.
        threshold = 24'h7FFFFF;
        configure(2, 3, 5, 3);
        repeat (30) begin
            input_data = 12'($urandom_range(0, 4095));
            step();
        end
        configure(2, 3, 3, 1023);
        for (int i = 0; i < 36; i++) begin
            input_data = (((i / 3) % 2) == 0) ? 12'd4095 : 12'd0;
            step();
        end

        // Reload during settling restarts the busy count.
        configure(1, 4, 4, 0);
        cfg_mode = 2'd1; cfg_k = 5'd4; cfg_l = 5'd4; cfg_load = 1'b1;
        step();
        repeat (4) step();
        cfg_mode = 2'd1; cfg_k = 5'd1; cfg_l = 5'd1; cfg_load = 1'b1;
        step();
        bl = busy ? 1 : 0;
        for (int i = 0; i < 64 && busy; i++) begin
            step();
            if (busy) bl++;
        end
        check("busy_restart", bl, 7);

        // Config acceptance table against a streaming trapezoid.
        configure(2, 4, 8, 0);
        input_data = 12'd100;
        repeat (15) step();
        for (int t = 0; t < 8; t++) begin
            cfg_mode = 2'(tbl[t].mode);
            cfg_k    = 5'(tbl[t].k);
            cfg_l    = 5'(tbl[t].l);
            cfg_m    = 10'(tbl[t].m);
            cfg_load = 1'b1;
            step();
            check("tbl_cfg_err", longint'(cfg_err), tbl[t].err);
            bl = busy ? 1 : 0;
            for (int i = 0; i < 64 && busy; i++) begin
                step();
                if (busy) bl++;
            end
            check("tbl_busy_len", bl, tbl[t].busy_len);
            repeat (3) step();
        end

        // Reset in the middle of operation behaves like power-up.
        reset = 1'b0;
        step();
        check("midrst_peak_value", longint'(peak_value), 0);
        reset = 1'b1;
        repeat (12) begin
            input_data = 12'($urandom_range(0, 4095));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
